// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared constants for the instruction fetch front end
//
// Purpose: widths, PC step, the two program entry points, FSM state
// encodings and the canonical NOP word used by the fetch unit.
// Ports: none (package).

package riscv_fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [PC_W-1:0] RESET_PC_P0 = 8'h00;
  localparam logic [PC_W-1:0] RESET_PC_P1 = 8'h40;

  // One flop is enough for two states; kept as plain constants so older
  // tools that dislike enums in ports can still consume the encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_next.sv
// rtl/fetch_pc_next.sv - combinational next-PC select and alignment check
//
// Purpose: picks the next PC from redirect target, sequential step or hold,
// and flags a redirect target that is not word aligned.
// Ports:
//   pc_q            in   current PC
//   redirect_valid  in   branch/jump taken this cycle (highest priority)
//   redirect_target in   requested new PC (low two bits forced to zero)
//   advance         in   a word is being captured, step the PC
//   pc_d            out  next PC
//   misalign        out  redirect requested with target[1:0] != 0

module fetch_pc_next #(
  parameter int PC_W    = 8,
  parameter int PC_STEP = 4
) (
  input  logic [PC_W-1:0] pc_q,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            advance,
  output logic [PC_W-1:0] pc_d,
  output logic            misalign
);

  always_comb begin
    pc_d     = pc_q;
    misalign = 1'b0;
    if (redirect_valid) begin
      pc_d     = {redirect_target[PC_W-1:2], 2'b00};
      misalign = |redirect_target[1:0];
    end else if (advance) begin
      // Natural modulo-2^PC_W wrap, so the top word rolls over to 0.
      pc_d = pc_q + PC_W'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with decode handshake
//
// Purpose: owns the PC, addresses the combinational instruction memory,
// registers the returned word and offers it to decode over valid/ready.
// Handles stall, branch/jump redirect with flush, a sticky misaligned-target
// flag and a saturating count of accepted fetches.
// Ports:
//   sysclk, rst          clock, synchronous active-high reset
//   enable               1 = fetch allowed; 0 = freeze PC, drain only
//   imem_addr/imem_instr instruction memory address out / data in (same cycle)
//   redirect_valid/_target  taken branch or jump and its new PC
//   fd_valid/fd_ready    handshake towards decode
//   fd_instr/fd_pc       fetched word and its address
//   misalign_err         sticky misaligned redirect target flag
//   fetch_count          saturating count of accepted handshakes

module fetch_unit #(
  parameter int                       PC_W     = 8,
  parameter int                       INSTR_W  = 32,
  parameter logic [PC_W-1:0]          RESET_PC = riscv_fetch_pkg::RESET_PC_P0,
  parameter int                       CNT_W    = 16
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               enable,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               fd_valid,
  input  logic               fd_ready,
  output logic [INSTR_W-1:0] fd_instr,
  output logic [PC_W-1:0]    fd_pc,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   fetch_count
);

  import riscv_fetch_pkg::*;

  logic [0:0]         state_q,    state_d;
  logic [PC_W-1:0]    pc_q,       pc_d;
  logic               fd_valid_q, fd_valid_d;
  logic [INSTR_W-1:0] fd_instr_q, fd_instr_d;
  logic [PC_W-1:0]    fd_pc_q,    fd_pc_d;
  logic               misalign_q, misalign_d;
  logic [CNT_W-1:0]   count_q,    count_d;

  logic accept;
  logic space;
  logic capture;
  logic tgt_misalign;

  assign accept  = fd_valid_q & fd_ready;
  assign space   = ~fd_valid_q | fd_ready;
  // Fetch only while running and still enabled; a redirect suppresses the
  // capture because the word at pc_q belongs to the squashed path.
  assign capture = (state_q == ST_RUN) & enable & space & ~redirect_valid;

  fetch_pc_next #(
    .PC_W    (PC_W),
    .PC_STEP (PC_STEP)
  ) u_pc_next (
    .pc_q            (pc_q),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .advance         (capture),
    .pc_d            (pc_d),
    .misalign        (tgt_misalign)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (enable) state_d = ST_RUN;
    end else begin
      if (!enable) state_d = ST_IDLE;
    end
  end

  always_comb begin
    fd_valid_d = fd_valid_q;
    fd_instr_d = fd_instr_q;
    fd_pc_d    = fd_pc_q;
    if (redirect_valid) begin
      // Flush; fd_instr/fd_pc keep their old contents but are no longer valid.
      fd_valid_d = 1'b0;
    end else if (capture) begin
      fd_valid_d = 1'b1;
      fd_instr_d = imem_instr;
      fd_pc_d    = pc_q;
    end else if (accept) begin
      // Draining while frozen: the held word leaves and nothing replaces it.
      fd_valid_d = 1'b0;
    end
  end

  always_comb begin
    misalign_d = misalign_q | tgt_misalign;
    count_d    = count_q;
    // The accept counts even in a redirect cycle: that word did reach decode.
    if (accept && !(&count_q)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fd_valid_q <= 1'b0;
      fd_instr_q <= '0;
      fd_pc_q    <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fd_valid_q <= fd_valid_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr    = pc_q;
  assign fd_valid     = fd_valid_q;
  assign fd_instr     = fd_instr_q;
  assign fd_pc        = fd_pc_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for the instruction fetch front end

module tb_fetch_unit;

  logic        sysclk;
  logic        rst;
  logic        enable;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_instr;
  logic [7:0]  fd_pc;
  logic        misalign_err;
  logic [15:0] fetch_count;

  fetch_unit dut (
    .sysclk          (sysclk),
    .rst             (rst),
    .enable          (enable),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fd_valid        (fd_valid),
    .fd_ready        (fd_ready),
    .fd_instr        (fd_instr),
    .fd_pc           (fd_pc),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Instruction memory: 64 words, combinational read.
  logic [31:0] mem [64];
  assign imem_instr = mem[imem_addr[7:2]];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: a fetch stream of sequential words that restarts at
  // each redirect; one held word at most; count of delivered words.
  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } word_t;

  word_t sb[$];
  int    m_pc    = 0;
  bit    m_valid = 0;
  bit    m_run   = 0;
  bit    m_err   = 0;
  int    m_cnt   = 0;

  logic [7:0]  exp_pc;
  bit          exp_valid;
  bit          exp_err;
  logic [15:0] exp_cnt;
  bit          mon_en = 0;

  task automatic model_step();
    bit acc;
    acc = m_valid && fd_ready;
    if (rst) begin
      m_pc = 0; m_valid = 0; m_run = 0; m_cnt = 0; m_err = 0;
      return;
    end
    if (acc && m_cnt < 65535) m_cnt++;
    if (redirect_valid) begin
      m_pc    = int'(redirect_target) & 'hFC;
      if (int'(redirect_target) % 4 != 0) m_err = 1;
      m_valid = 0;
    end else if (m_run && enable && (!m_valid || fd_ready)) begin
      sb.push_back('{m_pc[7:0], mem[m_pc / 4]});
      m_valid = 1;
      m_pc    = (m_pc + 4) % 256;
    end else if (acc) begin
      m_valid = 0;
    end
    m_run = enable;
  endtask

  // Inputs for this cycle must already be driven; called at a falling edge.
  task automatic tick();
    exp_pc    = m_pc[7:0];
    exp_valid = m_valid;
    exp_err   = m_err;
    exp_cnt   = m_cnt[15:0];
    mon_en    = 1;
    model_step();
    @(negedge sysclk);
  endtask

  // Monitor: compares DUT against the model snapshot each cycle and retires
  // scoreboard entries when the held word leaves (accept, flush or reset).
  initial begin
    forever begin
      @(negedge sysclk);
      #2;
      if (mon_en) begin
        check("fd_valid", 32'(fd_valid), 32'(exp_valid));
        check("imem_addr", 32'(imem_addr), 32'(exp_pc));
        check("fetch_count", 32'(fetch_count), 32'(exp_cnt));
        check("misalign_err", 32'(misalign_err), 32'(exp_err));
        if (exp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=valid required=queued_word");
          end else begin
            check("fd_pc", 32'(fd_pc), 32'(sb[0].pc));
            check("fd_instr", fd_instr, sb[0].instr);
            if (fd_ready || redirect_valid || rst) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[8'h00 >> 2] = 32'h02a00293;
    mem[8'h04 >> 2] = 32'h02100313;
    mem[8'h08 >> 2] = 32'h006283b3;
    mem[8'h0c >> 2] = 32'h00000063;
    mem[8'h40 >> 2] = 32'h00000533;
    mem[8'h44 >> 2] = 32'h00052283;

    rst = 1; enable = 0; fd_ready = 0; redirect_valid = 0; redirect_target = 0;
    repeat (2) @(negedge sysclk);
    tick();
    tick();
    check("reset_fd_valid", 32'(fd_valid), 0);
    check("reset_imem_addr", 32'(imem_addr), 0);
    check("reset_count", 32'(fetch_count), 0);

    // T1: back-to-back fetch from reset
    rst = 0; enable = 1; fd_ready = 1;
    repeat (6) tick();
    check("t1_count", 32'(fetch_count), 4);
    check("t1_fd_pc", 32'(fd_pc), 32'h10);

    // T2: stall on the first word
    rst = 1; tick();
    rst = 0;
    tick();
    tick();
    fd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_fd_pc", 32'(fd_pc), 0);
      check("t2_fd_instr", fd_instr, 32'h02a00293);
      check("t2_imem_addr", 32'(imem_addr), 32'h04);
      check("t2_count", 32'(fetch_count), 0);
    end
    fd_ready = 1;

    // T3: redirect to 40 while a word is held (and accepted)
    redirect_valid = 1; redirect_target = 8'h40; tick();
    redirect_valid = 0;
    check("t3_flush", 32'(fd_valid), 0);
    tick();
    check("t3_pc40", 32'(fd_pc), 32'h40);
    check("t3_instr40", fd_instr, 32'h00000533);
    tick();
    check("t3_pc44", 32'(fd_pc), 32'h44);
    check("t3_instr44", fd_instr, 32'h00052283);

    // T4: redirect to FC and wrap
    redirect_valid = 1; redirect_target = 8'hFC; tick();
    redirect_valid = 0;
    tick();
    check("t4_pcfc", 32'(fd_pc), 32'hFC);
    tick();
    check("t4_pc00", 32'(fd_pc), 32'h00);
    check("t4_instr00", fd_instr, 32'h02a00293);
    tick();
    check("t4_pc04", 32'(fd_pc), 32'h04);

    // T5: misaligned redirect
    redirect_valid = 1; redirect_target = 8'h42; tick();
    redirect_valid = 0;
    tick();
    check("t5_pc40", 32'(fd_pc), 32'h40);
    check("t5_instr40", fd_instr, 32'h00000533);
    check("t5_err", 32'(misalign_err), 1);
    repeat (3) tick();
    check("t5_err_sticky", 32'(misalign_err), 1);

    // T6: reset during a stall at 48, enable low
    redirect_valid = 1; redirect_target = 8'h48; tick();
    redirect_valid = 0;
    tick();
    fd_ready = 0;
    tick();
    check("t6_pc48", 32'(fd_pc), 32'h48);
    rst = 1; enable = 0; tick();
    rst = 0;
    check("t6_fd_valid", 32'(fd_valid), 0);
    check("t6_imem_addr", 32'(imem_addr), 0);
    check("t6_count", 32'(fetch_count), 0);
    check("t6_err", 32'(misalign_err), 0);
    repeat (2) tick();
    check("t6_idle", 32'(fd_valid), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable          = ($urandom_range(9) != 0);
      fd_ready        = ($urandom_range(3) != 0);
      redirect_valid  = ($urandom_range(9) == 0);
      redirect_target = 8'($urandom);
      rst             = ($urandom_range(99) == 0);
      tick();
    end
    rst = 0; redirect_valid = 0; enable = 0; fd_ready = 1;
    repeat (3) tick();
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
